// File: rtl/game_control_n_if.sv
// Game controller port bundle: player/datapath inputs and
// datapath control outputs, with controller/datapath views.
interface game_control_n_if #(
    parameter int IDX_W = 2
);
    logic             load;
    logic             new_game;
    logic             exact_match;
    logic             load_code;
    logic             load_guess;
    logic [IDX_W-1:0] peg_sel;
    logic             compare;
    logic [IDX_W-1:0] compare_i;
    logic             result_done;
    logic [3:0]       round;
    logic             win;
    logic             lose;

    modport master (
        input  load,
        input  new_game,
        input  exact_match,
        output load_code,
        output load_guess,
        output peg_sel,
        output compare,
        output compare_i,
        output result_done,
        output round,
        output win,
        output lose
    );

    modport slave (
        output load,
        output new_game,
        output exact_match,
        input  load_code,
        input  load_guess,
        input  peg_sel,
        input  compare,
        input  compare_i,
        input  result_done,
        input  round,
        input  win,
        input  lose
    );
endinterface

// File: rtl/game_control_n.sv
// Code-breaking game controller FSM with registered Moore outputs.
// Define ROUND_LIMIT_EN to end the game after MAX_ROUNDS misses.
module game_control_n #(
    parameter int NUM_PEGS   = 4,
    parameter int MAX_ROUNDS = 10
) (
    input logic              clk,
    input logic              resetn,
    game_control_n_if.master bus
);
    localparam int IDX_W =
        (NUM_PEGS > 2) ? $clog2(NUM_PEGS) : 1;
    localparam int RND_W = 4;
    localparam logic [IDX_W-1:0] LAST =
        IDX_W'(NUM_PEGS - 1);
    localparam logic [RND_W-1:0] RLAST =
        RND_W'(MAX_ROUNDS - 1);
`ifdef ROUND_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_LOAD_CODE,
        S_LOAD_CODE_WAIT,
        S_GUESS,
        S_GUESS_WAIT,
        S_COMPARE,
        S_CHECK,
        S_WIN,
        S_LOSE
    } state_t;

    state_t           state, state_d;
    logic [IDX_W-1:0] peg_cnt, peg_d;
    logic [IDX_W-1:0] cmp_cnt, cmp_d;
    logic [RND_W-1:0] round_q, rnd_d;

    logic             load_code_q;
    logic             load_guess_q;
    logic [IDX_W-1:0] peg_sel_q;
    logic             compare_q;
    logic [IDX_W-1:0] compare_i_q;
    logic             result_done_q;
    logic             win_q;
    logic             lose_q;
    logic             limit_hit;

    assign limit_hit = LIMIT_EN && (round_q >= RLAST);

    always_comb begin
        state_d = state;
        peg_d   = peg_cnt;
        cmp_d   = cmp_cnt;
        rnd_d   = round_q;
        if (bus.new_game) begin
            state_d = S_LOAD_CODE;
            peg_d   = '0;
            cmp_d   = '0;
            rnd_d   = '0;
        end else begin
            unique case (state)
                S_LOAD_CODE:
                    if (bus.load) state_d = S_LOAD_CODE_WAIT;
                S_LOAD_CODE_WAIT:
                    if (!bus.load) begin
                        if (peg_cnt == LAST) begin
                            peg_d   = '0;
                            state_d = S_GUESS;
                        end else begin
                            peg_d   = peg_cnt + IDX_W'(1);
                            state_d = S_LOAD_CODE;
                        end
                    end
                S_GUESS:
                    if (bus.load) state_d = S_GUESS_WAIT;
                S_GUESS_WAIT:
                    if (!bus.load) begin
                        if (peg_cnt == LAST) begin
                            peg_d   = '0;
                            cmp_d   = '0;
                            state_d = S_COMPARE;
                        end else begin
                            peg_d   = peg_cnt + IDX_W'(1);
                            state_d = S_GUESS;
                        end
                    end
                S_COMPARE:
                    if (cmp_cnt == LAST) state_d = S_CHECK;
                    else cmp_d = cmp_cnt + IDX_W'(1);
                S_CHECK:
                    if (bus.exact_match) begin
                        state_d = S_WIN;
                    end else if (limit_hit) begin
                        state_d = S_LOSE;
                    end else begin
                        // round sticks at 15 rather than wrapping
                        if (round_q != '1)
                            rnd_d = round_q + RND_W'(1);
                        peg_d   = '0;
                        state_d = S_GUESS;
                    end
                S_WIN:  state_d = S_WIN;
                S_LOSE: state_d = S_LOSE;
                default: state_d = S_LOAD_CODE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up
    // with the registered state in the same cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= S_LOAD_CODE;
            peg_cnt       <= '0;
            cmp_cnt       <= '0;
            round_q       <= '0;
            load_code_q   <= 1'b1;
            load_guess_q  <= 1'b0;
            peg_sel_q     <= '0;
            compare_q     <= 1'b0;
            compare_i_q   <= '0;
            result_done_q <= 1'b0;
            win_q         <= 1'b0;
            lose_q        <= 1'b0;
        end else begin
            state         <= state_d;
            peg_cnt       <= peg_d;
            cmp_cnt       <= cmp_d;
            round_q       <= rnd_d;
            load_code_q   <= (state_d == S_LOAD_CODE);
            load_guess_q  <= (state_d == S_GUESS);
            peg_sel_q     <= (state_d == S_LOAD_CODE ||
                              state_d == S_GUESS) ? peg_d : '0;
            compare_q     <= (state_d == S_COMPARE);
            compare_i_q   <= (state_d == S_COMPARE) ? cmp_d : '0;
            result_done_q <= (state_d == S_COMPARE) &&
                             (cmp_d == LAST);
            win_q         <= (state_d == S_WIN);
            lose_q        <= LIMIT_EN && (state_d == S_LOSE);
        end
    end

    assign bus.load_code   = load_code_q;
    assign bus.load_guess  = load_guess_q;
    assign bus.peg_sel     = peg_sel_q;
    assign bus.compare     = compare_q;
    assign bus.compare_i   = compare_i_q;
    assign bus.result_done = result_done_q;
    assign bus.round       = round_q;
    assign bus.win         = win_q;
    assign bus.lose        = lose_q;
endmodule

// File: tb/tb_game_control_n.sv
// Bench for game_control_n: directed table, corner sequences and
// random play checked against a behavioural game model.
module tb_game_control_n;
    localparam int NP = 4;
    localparam int MR = 3;
    localparam int IW = 2;
`ifdef ROUND_LIMIT_EN
    localparam bit LIM = 1'b1;
`else
    localparam bit LIM = 1'b0;
`endif

    localparam int M_CODE  = 0;
    localparam int M_GUESS = 1;
    localparam int M_CMP   = 2;
    localparam int M_CHK   = 3;
    localparam int M_WON   = 4;
    localparam int M_LOST  = 5;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    game_control_n_if #(.IDX_W(IW)) bus ();

    game_control_n #(
        .NUM_PEGS  (NP),
        .MAX_ROUNDS(MR)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    int m_mode, m_peg, m_cmp, m_rnd;
    bit m_held;

    typedef struct {
        logic        l;
        logic        ng;
        logic        em;
        logic [13:0] exp;
    } vec_t;
    vec_t tbl[21];

    function automatic logic [13:0] ev(
        bit lc, bit lg, int ps, bit cp, int ci,
        bit rd, int rnd, bit w
    );
        return {lc, lg, 2'(ps), cp, 2'(ci), rd,
                4'(rnd), w, 1'b0};
    endfunction

    function automatic logic [13:0] actual();
        return {bus.load_code, bus.load_guess, bus.peg_sel,
                bus.compare, bus.compare_i, bus.result_done,
                bus.round, bus.win, bus.lose};
    endfunction

    function automatic logic [13:0] model_out();
        bit lc, lg, cp, rd;
        int ps, ci;
        lc = (m_mode == M_CODE) && !m_held;
        lg = (m_mode == M_GUESS) && !m_held;
        ps = (lc || lg) ? m_peg : 0;
        cp = (m_mode == M_CMP);
        ci = cp ? m_cmp : 0;
        rd = cp && (m_cmp == NP - 1);
        return {lc, lg, 2'(ps), cp, 2'(ci), rd, 4'(m_rnd),
                m_mode == M_WON, m_mode == M_LOST};
    endfunction

    task automatic model_reset();
        m_mode = M_CODE;
        m_peg  = 0;
        m_cmp  = 0;
        m_rnd  = 0;
        m_held = 1'b0;
    endtask

    // One clock of game rules: a peg counts on release.
    task automatic model_step(bit l, bit ng, bit em);
        if (ng) begin
            model_reset();
        end else if (m_mode == M_CODE || m_mode == M_GUESS) begin
            if (!m_held) begin
                if (l) m_held = 1'b1;
            end else if (!l) begin
                m_held = 1'b0;
                if (m_peg == NP - 1) begin
                    m_peg = 0;
                    if (m_mode == M_CODE) begin
                        m_mode = M_GUESS;
                    end else begin
                        m_mode = M_CMP;
                        m_cmp  = 0;
                    end
                end else begin
                    m_peg++;
                end
            end
        end else if (m_mode == M_CMP) begin
            if (m_cmp == NP - 1) m_mode = M_CHK;
            else m_cmp++;
        end else if (m_mode == M_CHK) begin
            if (em) begin
                m_mode = M_WON;
            end else if (LIM && m_rnd == MR - 1) begin
                m_mode = M_LOST;
            end else begin
                m_rnd  = (m_rnd < 15) ? m_rnd + 1 : 15;
                m_peg  = 0;
                m_mode = M_GUESS;
            end
        end
    endtask

    task automatic check(string name, logic [13:0] act,
                         logic [13:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h",
                     name, act, exp);
        end
    endtask

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d",
                     name, act, exp);
        end
    endtask

    task automatic drive(bit l, bit ng, bit em);
        bus.load        = l;
        bus.new_game    = ng;
        bus.exact_match = em;
        model_step(l, ng, em);
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(bit l, bit ng, bit em, string name);
        drive(l, ng, em);
        check(name, actual(), model_out());
    endtask

    task automatic load_pegs(string name);
        for (int i = 0; i < NP; i++) begin
            cyc(1'b1, 1'b0, 1'b0, name);
            cyc(1'b0, 1'b0, 1'b0, name);
        end
    endtask

    task automatic play_round(bit em);
        load_pegs("guess_pegs");
        for (int i = 0; i < NP; i++)
            cyc(1'b0, 1'b0, 1'b0, "compare_run");
        cyc(1'b0, 1'b0, em, "check_cycle");
    endtask

    initial begin
        tbl[0]  = '{1, 0, 0, ev(0,0,0,0,0,0,0,0)};
        tbl[1]  = '{0, 0, 0, ev(1,0,1,0,0,0,0,0)};
        tbl[2]  = '{1, 0, 0, ev(0,0,0,0,0,0,0,0)};
        tbl[3]  = '{0, 0, 0, ev(1,0,2,0,0,0,0,0)};
        tbl[4]  = '{1, 0, 0, ev(0,0,0,0,0,0,0,0)};
        tbl[5]  = '{0, 0, 0, ev(1,0,3,0,0,0,0,0)};
        tbl[6]  = '{1, 0, 0, ev(0,0,0,0,0,0,0,0)};
        tbl[7]  = '{0, 0, 0, ev(0,1,0,0,0,0,0,0)};
        tbl[8]  = '{1, 0, 0, ev(0,0,0,0,0,0,0,0)};
        tbl[9]  = '{0, 0, 0, ev(0,1,1,0,0,0,0,0)};
        tbl[10] = '{1, 0, 0, ev(0,0,0,0,0,0,0,0)};
        tbl[11] = '{0, 0, 0, ev(0,1,2,0,0,0,0,0)};
        tbl[12] = '{1, 0, 0, ev(0,0,0,0,0,0,0,0)};
        tbl[13] = '{0, 0, 0, ev(0,1,3,0,0,0,0,0)};
        tbl[14] = '{1, 0, 1, ev(0,0,0,0,0,0,0,0)};
        tbl[15] = '{0, 0, 1, ev(0,0,0,1,0,0,0,0)};
        tbl[16] = '{0, 0, 1, ev(0,0,0,1,1,0,0,0)};
        tbl[17] = '{0, 0, 1, ev(0,0,0,1,2,0,0,0)};
        tbl[18] = '{0, 0, 1, ev(0,0,0,1,3,1,0,0)};
        tbl[19] = '{0, 0, 0, ev(0,0,0,0,0,0,0,0)};
        tbl[20] = '{0, 0, 0, ev(0,1,0,0,0,0,1,0)};

        bus.load        = 1'b0;
        bus.new_game    = 1'b0;
        bus.exact_match = 1'b0;
        resetn          = 1'b0;
        model_reset();
        #12;
        check("reset_state", actual(), ev(1,0,0,0,0,0,0,0));
        resetn = 1'b1;

        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].l, tbl[i].ng, tbl[i].em);
            check($sformatf("table_%0d", i), actual(), tbl[i].exp);
        end

        // win in round 1, hold, then restart
        play_round(1'b1);
        chk("win_flag", int'(bus.win), 1);
        chk("win_round", int'(bus.round), 1);
        for (int i = 0; i < 20; i++)
            cyc(1'($urandom % 2), 1'b0, 1'($urandom % 2),
                "win_hold");
        chk("win_held", int'(bus.win), 1);
        cyc(1'b0, 1'b1, 1'b0, "new_game");
        chk("ng_load_code", int'(bus.load_code), 1);
        chk("ng_round", int'(bus.round), 0);
        chk("ng_win", int'(bus.win), 0);

        // long press loads only one peg
        for (int i = 0; i < 50; i++)
            cyc(1'b1, 1'b0, 1'b0, "long_press");
        chk("long_press_wait", int'(bus.load_code), 0);
        cyc(1'b0, 1'b0, 1'b0, "long_release");
        chk("long_peg_sel", int'(bus.peg_sel), 1);
        for (int i = 1; i < NP; i++) begin
            cyc(1'b1, 1'b0, 1'b0, "code_rest");
            cyc(1'b0, 1'b0, 1'b0, "code_rest");
        end

        for (int r = 0; r < MR; r++) play_round(1'b0);
        if (LIM) begin
            chk("lose_flag", int'(bus.lose), 1);
            chk("lose_round", int'(bus.round), MR - 1);
            for (int i = 0; i < 5; i++)
                cyc(1'b1, 1'b0, 1'b1, "lose_hold");
            chk("lose_held", int'(bus.lose), 1);
        end else begin
            chk("nolimit_round", int'(bus.round), MR);
            chk("nolimit_guess", int'(bus.load_guess), 1);
            chk("nolimit_lose", int'(bus.lose), 0);
            for (int r = 0; r < 14; r++) play_round(1'b0);
            chk("round_saturate", int'(bus.round), 15);
        end

        // new_game beats exact_match in CHECK
        cyc(1'b0, 1'b1, 1'b0, "restart");
        load_pegs("code_pegs");
        load_pegs("guess_pegs2");
        for (int i = 0; i < NP; i++)
            cyc(1'b0, 1'b0, 1'b0, "compare_run2");
        cyc(1'b0, 1'b1, 1'b1, "ng_vs_match");
        chk("ng_prio_win", int'(bus.win), 0);
        chk("ng_prio_lc", int'(bus.load_code), 1);
        cyc(1'b1, 1'b1, 1'b0, "ng_vs_load");
        chk("ng_load_prio", int'(bus.load_code), 1);

        // asynchronous reset mid-compare after one missed round
        load_pegs("code_pegs2");
        play_round(1'b0);
        load_pegs("guess_pegs3");
        cyc(1'b0, 1'b0, 1'b0, "cmp1");
        cyc(1'b0, 1'b0, 1'b0, "cmp2");
        chk("pre_rst_ci", int'(bus.compare_i), 2);
        chk("pre_rst_round", int'(bus.round), 1);
        #2 resetn = 1'b0;
        #1;
        model_reset();
        check("async_reset", actual(), ev(1,0,0,0,0,0,0,0));
        #3 resetn = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, "post_reset");

        for (int i = 0; i < 3000; i++)
            cyc(1'($urandom % 2), 1'($urandom % 64 == 0),
                1'($urandom % 3 == 0), "random");

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end
endmodule
